program_memory_loader: RTL and testbench

//  Writer side of the program RAM: accepts a byte stream (valid/ready) from the host/boot link,

---
 rtl/program_memory_loader_pkg.sv | 23 ++
 rtl/program_memory_loader_byte_word_packer.sv | 57 +++++
 rtl/program_memory_loader.sv | 144 ++++++++++++++
 tb/tb_program_memory_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_memory_loader_pkg.sv
// Shared definitions for the program memory loader: FSM state encoding,
// byte geometry and helpers for deriving the packer index width.
package program_memory_loader_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2
   } load_state_e;

   // Number of whole bytes that make up one RAM word.
   function automatic int bytes_per_word(input int word_w);
      return word_w / BYTE_W;
   endfunction

   // Width of a counter that indexes bytes within a word; never narrower than 1 bit.
   function automatic int byte_idx_width(input int bpw);
      return (bpw > 1) ? $clog2(bpw) : 1;
   endfunction

endpackage

// File: rtl/program_memory_loader_byte_word_packer.sv
// Byte-to-word packer: shifts bytes in MSB-first, tracks the byte index
// within the current word and zero-pads the tail when the image ends early.
// word_nxt_o is the word as it will look after the current byte is taken,
// so the FSM can register it on the same edge that completes the word.
module program_memory_loader_byte_word_packer
   import program_memory_loader_pkg::*;
#(
   parameter int m = 16
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         clear_i,
   input  logic         shift_i,
   input  logic [7:0]   byte_i,
   input  logic         last_i,
   output logic         word_ready_o,
   output logic [m-1:0] word_nxt_o
);

   localparam int BPW   = bytes_per_word(m);
   localparam int IDX_W = byte_idx_width(BPW);

   logic [m-1:0]     word_q;
   logic [m-1:0]     word_base;
   logic [IDX_W-1:0] idx_q;
   logic             idx_full;

   assign idx_full = (idx_q == IDX_W'(BPW - 1));

   // Place the incoming byte at its slot; the first byte of a word starts from
   // zero so any slots not reached before byte_last stay zero-padded.
   always_comb begin
      word_base  = (idx_q == '0) ? '0 : word_q;
      word_nxt_o = word_base;
      for (int b = 0; b < BPW; b++) begin
         if (idx_q == IDX_W'(b)) begin
            word_nxt_o[m-1-BYTE_W*b -: BYTE_W] = byte_i;
         end
      end
      word_ready_o = shift_i & (idx_full | last_i);
   end

   // Pack register and byte index; index returns to 0 whenever a word completes.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         word_q <= '0;
         idx_q  <= '0;
      end else if (clear_i) begin
         word_q <= '0;
         idx_q  <= '0;
      end else if (shift_i) begin
         word_q <= word_nxt_o;
         idx_q  <= word_ready_o ? '0 : idx_q + IDX_W'(1);
      end
   end

endmodule

// File: rtl/program_memory_loader.sv
// Writer side of the program RAM. Accepts a valid/ready byte stream, packs it
// into m-bit words and writes them at ascending addresses, keeping the RAM
// read port disabled for the duration of the load.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; read port enabled, stream not accepted
// ST_LOAD  | accepting bytes into the packer until a word completes
// ST_WRITE | one-cycle RAM write of the packed word, then advance/finish
module program_memory_loader
   import program_memory_loader_pkg::*;
#(
   parameter int n = 4,
   parameter int m = 16
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         start,
   input  logic [7:0]   byte_in,
   input  logic         byte_valid,
   input  logic         byte_last,
   output logic         byte_ready,
   output logic [n-1:0] mem_address,
   output logic [m-1:0] mem_data_in,
   output logic         mem_write,
   output logic         mem_enable,
   output logic         busy,
   output logic         done,
   output logic         overflow,
   output logic [n:0]   word_count
);

   localparam logic [n-1:0] ADDR_MAX = '1;

   load_state_e  state_q;
   logic         byte_ready_q;
   logic [n-1:0] addr_q;
   logic [m-1:0] data_q;
   logic         mem_write_q;
   logic         mem_enable_q;
   logic         busy_q;
   logic         done_q;
   logic         overflow_q;
   logic [n:0]   count_q;
   logic         last_q;

   logic         xfer;
   logic         pack_clear;
   logic         word_ready;
   logic [m-1:0] word_nxt;

   assign xfer       = byte_valid & byte_ready_q;
   assign pack_clear = (state_q == ST_IDLE) & start;

   program_memory_loader_byte_word_packer #(
      .m (m)
   ) u_packer (
      .clk          (clk),
      .clr_n        (clr_n),
      .clear_i      (pack_clear),
      .shift_i      (xfer),
      .byte_i       (byte_in),
      .last_i       (byte_last),
      .word_ready_o (word_ready),
      .word_nxt_o   (word_nxt)
   );

   // Load sequencer with all outputs registered.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_q      <= ST_IDLE;
         byte_ready_q <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         mem_write_q  <= 1'b0;
         mem_enable_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
         count_q      <= '0;
         last_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q      <= ST_LOAD;
                  byte_ready_q <= 1'b1;
                  busy_q       <= 1'b1;
                  mem_enable_q <= 1'b0;
                  addr_q       <= '0;
                  count_q      <= '0;
                  done_q       <= 1'b0;
                  overflow_q   <= 1'b0;
                  last_q       <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (word_ready) begin
                  state_q      <= ST_WRITE;
                  byte_ready_q <= 1'b0;
                  mem_write_q  <= 1'b1;
                  data_q       <= word_nxt;
                  last_q       <= byte_last;
               end
            end
            ST_WRITE: begin
               mem_write_q <= 1'b0;
               count_q     <= count_q + (n+1)'(1);
               // Stopping at the top address without a last byte means the
               // image did not fit; the rest of the stream is left untouched.
               if (last_q || (addr_q == ADDR_MAX)) begin
                  state_q      <= ST_IDLE;
                  busy_q       <= 1'b0;
                  mem_enable_q <= 1'b1;
                  done_q       <= 1'b1;
                  overflow_q   <= ~last_q;
               end else begin
                  state_q      <= ST_LOAD;
                  byte_ready_q <= 1'b1;
                  addr_q       <= addr_q + n'(1);
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               byte_ready_q <= 1'b0;
               mem_write_q  <= 1'b0;
               busy_q       <= 1'b0;
               mem_enable_q <= 1'b1;
            end
         endcase
      end
   end

   assign byte_ready  = byte_ready_q;
   assign mem_address = addr_q;
   assign mem_data_in = data_q;
   assign mem_write   = mem_write_q;
   assign mem_enable  = mem_enable_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign overflow    = overflow_q;
   assign word_count  = count_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Bench for program_memory_loader (n=4, m=16): directed loads, expected RAM
// writes queued at stimulus time and popped by an independent write monitor.
module tb_program_memory_loader;

   localparam int N = 4;
   localparam int M = 16;

   logic          clk = 1'b0;
   logic          clr_n;
   logic          start;
   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          byte_last;
   logic          byte_ready;
   logic [N-1:0]  mem_address;
   logic [M-1:0]  mem_data_in;
   logic          mem_write;
   logic          mem_enable;
   logic          busy;
   logic          done;
   logic          overflow;
   logic [N:0]    word_count;

   program_memory_loader #(.n(N), .m(M)) dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .start       (start),
      .byte_in     (byte_in),
      .byte_valid  (byte_valid),
      .byte_last   (byte_last),
      .byte_ready  (byte_ready),
      .mem_address (mem_address),
      .mem_data_in (mem_data_in),
      .mem_write   (mem_write),
      .mem_enable  (mem_enable),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .word_count  (word_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] addr;
      logic [M-1:0] data;
   } wr_t;

   wr_t  exp_q[$];
   wr_t  mon_e;
   int   errors = 0;
   int   checks = 0;
   logic [7:0] img [0:33];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int a, input int d);
      wr_t w;
      w.addr = a[N-1:0];
      w.data = d[M-1:0];
      exp_q.push_back(w);
   endtask

   // Write monitor: every RAM write strobe must match the oldest expected write.
   initial begin
      forever begin
         @(negedge clk);
         if (clr_n === 1'b1 && mem_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                        mem_address, mem_data_in);
            end else begin
               mon_e = exp_q.pop_front();
               if (mem_address !== mon_e.addr || mem_data_in !== mon_e.data
                   || mem_enable !== 1'b0) begin
                  errors++;
                  $display("FAIL ram_write: got addr %0h data %0h en %0b, expected addr %0h data %0h en 0",
                           mem_address, mem_data_in, mem_enable, mon_e.addr, mon_e.data);
               end
            end
         end
      end
   end

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Present one byte, optionally preceded by idle gap cycles (with start pulses);
   // ok reports whether the loader took it within the timeout.
   task automatic send_byte(input logic [7:0] b, input logic last, input int timeout,
                            input int gap, input logic gap_start, output logic ok);
      int t;
      t  = 0;
      ok = 1'b0;
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         byte_valid = 1'b0;
         byte_last  = 1'b1;
         start      = gap_start & i[0];
      end
      @(negedge clk);
      start      = 1'b0;
      byte_in    = b;
      byte_valid = 1'b1;
      byte_last  = last;
      while (!byte_ready && t < timeout) begin
         @(negedge clk);
         t++;
      end
      if (byte_ready) begin
         @(posedge clk);
         ok = 1'b1;
      end
   endtask

   task automatic stream_end();
      #1;
      byte_valid = 1'b0;
      byte_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (busy && t < 100);
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", t);
      end
   endtask

   task automatic send_image(input int nbytes, input int last_at, input int max_gap,
                             input logic gap_start, input string tag);
      logic ok;
      for (int k = 0; k < nbytes; k++) begin
         send_byte(img[k], (k == last_at), 50,
                   (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, gap_start, ok);
         check({tag, "_accept"}, ok, 1);
      end
      stream_end();
   endtask

   task automatic check_final(input string tag, input int wc, input int dn,
                              input int ov, input int addr);
      check({tag, "_word_count"}, word_count, wc);
      check({tag, "_done"},       done, dn);
      check({tag, "_overflow"},   overflow, ov);
      check({tag, "_address"},    mem_address, addr);
      check({tag, "_enable"},     mem_enable, 1);
      check({tag, "_queue"},      exp_q.size(), 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ready"},   byte_ready, 0);
      check({tag, "_write"},   mem_write, 0);
      check({tag, "_addr"},    mem_address, 0);
      check({tag, "_data"},    mem_data_in, 0);
      check({tag, "_busy"},    busy, 0);
      check({tag, "_done"},    done, 0);
      check({tag, "_ovf"},     overflow, 0);
      check({tag, "_count"},   word_count, 0);
      check({tag, "_enable"},  mem_enable, 1);
   endtask

   initial begin
      logic ok;
      clr_n      = 1'b0;
      start      = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("por");
      clr_n = 1'b1;

      // Two-byte image: one word 1234 at address 0.
      do_start();
      check("t2_busy", busy, 1);
      check("t2_enable_low", mem_enable, 0);
      check("t2_ready", byte_ready, 1);
      push_exp(0, 16'h1234);
      img[0] = 8'h12;
      img[1] = 8'h34;
      send_image(2, 1, 0, 1'b0, "t2");
      wait_idle();
      check_final("t2", 1, 1, 0, 0);
      check("t2_data_hold", mem_data_in, 16'h1234);

      // Single byte with last: low byte zero-padded.
      do_start();
      check("t3_done_cleared", done, 0);
      push_exp(0, 16'hAB00);
      img[0] = 8'hAB;
      send_image(1, 0, 0, 1'b0, "t3");
      wait_idle();
      check_final("t3", 1, 1, 0, 0);

      // Exactly full image: 32 bytes, last on byte 31.
      for (int k = 0; k < 32; k++) img[k] = 8'(k * 17 + 3);
      for (int w = 0; w < 16; w++) push_exp(w, {img[2*w], img[2*w+1]});
      do_start();
      send_image(32, 31, 0, 1'b0, "t4");
      wait_idle();
      check_final("t4", 16, 1, 0, 15);

      // Reset mid-stream after one word written and one byte of the next.
      do_start();
      img[0] = 8'hC3;
      img[1] = 8'h5E;
      img[2] = 8'h77;
      push_exp(0, 16'hC35E);
      for (int k = 0; k < 3; k++) begin
         send_byte(img[k], 1'b0, 50, 0, 1'b0, ok);
         check("t1_accept", ok, 1);
      end
      @(negedge clk);
      check("t1_busy_before", busy, 1);
      clr_n = 1'b0;
      @(negedge clk);
      check_reset("t1");
      check("t1_queue", exp_q.size(), 0);
      clr_n      = 1'b1;
      byte_valid = 1'b0;

      // Oversized image: 34 bytes without last; only 32 consumed.
      for (int k = 0; k < 34; k++) img[k] = 8'(k) ^ 8'h5A;
      for (int w = 0; w < 16; w++) push_exp(w, {img[2*w], img[2*w+1]});
      do_start();
      for (int k = 0; k < 32; k++) begin
         send_byte(img[k], 1'b0, 50, 0, 1'b0, ok);
         check("t5_accept", ok, 1);
      end
      send_byte(img[32], 1'b0, 10, 0, 1'b0, ok);
      check("t5_byte33_rejected", ok, 0);
      send_byte(img[33], 1'b0, 10, 0, 1'b0, ok);
      check("t5_byte34_rejected", ok, 0);
      stream_end();
      wait_idle();
      check_final("t5", 16, 1, 1, 15);

      // Gappy stream with start pulses while busy: five bytes, last on the fifth.
      img[0] = 8'hDE;
      img[1] = 8'hAD;
      img[2] = 8'hBE;
      img[3] = 8'hEF;
      img[4] = 8'h42;
      push_exp(0, 16'hDEAD);
      push_exp(1, 16'hBEEF);
      push_exp(2, 16'h4200);
      do_start();
      check("t6_done_cleared", done, 0);
      check("t6_ovf_cleared", overflow, 0);
      send_image(5, 4, 3, 1'b1, "t6");
      wait_idle();
      check_final("t6", 3, 1, 0, 2);
      check("t6_data_hold", mem_data_in, 16'h4200);

      repeat (3) @(negedge clk);
      check("end_queue", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
